// File: rtl/gcd_unit.sv
// Subtractive GCD engine fed by a registered-read FIFO (A then B), result held under valid/ready.
// Optional CALC-cycle counter output cycles_o when GCD_UNIT_CYCLE_CNT_EN is defined.
module gcd_unit #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  rd_en_o,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  res_valid_o,
`ifdef GCD_UNIT_CYCLE_CNT_EN
    output logic [DATA_WIDTH:0]   cycles_o,
`endif
    input  logic                  res_ready_i
);

    // Result handshake: res_valid_o/res_o stay stable until a cycle with
    // res_ready_i=1; the transfer completes on that rising edge.
    typedef enum logic [2:0] {
        IDLE, RD_A, CAP_A, RD_B, CAP_B, CALC, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        rd_en_o     = 1'b0;
        res_valid_o = 1'b0;
        case (state_q)
            IDLE: state_d = RD_A;
            RD_A: begin
                rd_en_o = !fifo_empty_i;
                if (rd_en_o) state_d = CAP_A;
            end
            CAP_A: begin
                a_d     = fifo_data_i;
                state_d = RD_B;
            end
            RD_B: begin
                rd_en_o = !fifo_empty_i;
                if (rd_en_o) state_d = CAP_B;
            end
            CAP_B: begin
                b_d     = fifo_data_i;
                state_d = CALC;
            end
            CALC: begin
                // A zero operand ends the loop: gcd(x,0)=x, and gcd(0,0)=0 falls out.
                if (a_q == b_q || a_q == '0 || b_q == '0) begin
                    res_d   = (a_q == '0) ? b_q : a_q;
                    state_d = DONE;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_o = res_q;

`ifdef GCD_UNIT_CYCLE_CNT_EN
    logic [DATA_WIDTH:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == CAP_B)     cnt_d = '0;
        else if (state_q == CALC) cnt_d = cnt_q + (DATA_WIDTH+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cycles_o = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: FIFO model, Euclid reference model, result scoreboard.
module tb_gcd_unit;
    localparam int DW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          fifo_empty_i = 1'b1;
    logic [DW-1:0] fifo_data_i = '0;
    logic          rd_en_o;
    logic [DW-1:0] res_o;
    logic          res_valid_o;
    logic          res_ready_i;
`ifdef GCD_UNIT_CYCLE_CNT_EN
    logic [DW:0]   cycles_o;
`endif

    gcd_unit #(.DATA_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .rd_en_o     (rd_en_o),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
`ifdef GCD_UNIT_CYCLE_CNT_EN
        .cycles_o    (cycles_o),
`endif
        .res_ready_i (res_ready_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    int            calc_q[$];
    bit            first_q[$];
    logic [DW-1:0] push_q[$];
    logic [DW-1:0] fifo_q[$];
    int            pops_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtractions performed before a==b or a zero operand is reached.
    function automatic int ref_steps(input int a, input int b);
        int hi, lo;
        if (a == 0 || b == 0 || a == b) return 0;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        if (hi % lo == 0) return hi / lo - 1;
        return hi / lo + ref_steps(hi % lo, lo);
    endfunction

    // ---------------- FIFO model (registered read) ----------------
    initial begin
        bit pop_req;
        forever begin
            @(negedge clk_i);
            pop_req = rd_en_o;
            @(posedge clk_i);
            #1;
            if (pop_req) begin
                check("fifo_underflow", fifo_q.size() > 0, 1);
                if (fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
            end
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
            fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            pop_cnt = 0;
    int            first_pop = 0;
    int            second_pop = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_res = '0;

    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_cnt    = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            cyc++;
            if (rd_en_o) begin
                pops_total++;
                if (pop_cnt % 2 == 0) first_pop = cyc;
                else                  second_pop = cyc;
                pop_cnt++;
            end
            if (res_valid_o) check("rd_en_in_done", rd_en_o, 0);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", res_valid_o, 1);
                check("hold_res", res_o, prev_res);
            end
            if (res_valid_o && !prev_valid) begin
                check("valid_expected", exp_q.size() > 0, 1);
                if (calc_q.size() > 0) begin
                    check("lat_from_b", cyc - second_pop, 2 + calc_q[0]);
                    if (first_q[0]) check("lat_from_a", cyc - first_pop, 4 + calc_q[0]);
                end
            end
            if (res_valid_o && res_ready_i && exp_q.size() > 0) begin
                check("res", res_o, exp_q.pop_front());
`ifdef GCD_UNIT_CYCLE_CNT_EN
                check("cycles", cycles_o, calc_q[0]);
`endif
                void'(calc_q.pop_front());
                void'(first_q.pop_front());
            end
            prev_valid = res_valid_o;
            prev_ready = res_ready_i;
            prev_res   = res_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [DW-1:0] v);
        push_q.push_back(v);
    endtask

    task automatic add_exp(input int a, input int b, input bit chk_first);
        exp_q.push_back(DW'(ref_gcd(a, b)));
        calc_q.push_back(ref_steps(a, b) + 1);
        first_q.push_back(chk_first);
    endtask

    task automatic push_op(input int a, input int b, input bit chk_first);
        add_exp(a, b, chk_first);
        push_word(DW'(a));
        push_word(DW'(b));
    endtask

    task automatic wait_drain(input int budget, input bit rand_ready);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk_i);
            #1;
            if (rand_ready) res_ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        res_ready_i = 1'b1;
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops_total < target && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("pop_timeout", pops_total >= target, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        rst_ni      = 1'b0;
        res_ready_i = 1'b1;

        push_op(12, 8, 1);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rd_en", rd_en_o, 0);
        check("rst_valid", res_valid_o, 0);
        check("rst_res", res_o, 0);
        check("rst_no_pop", pops_total, 0);
        rst_ni = 1'b1;
        wait_drain(200, 0);
        check("pops_12_8", pops_total, 2);

        push_op(15, 10, 1);
        push_op(9, 6, 1);
        wait_drain(200, 0);

        push_op(0, 7, 1);
        push_op(0, 0, 1);
        wait_drain(200, 0);

        // Starve the FIFO while waiting for B.
        base = pops_total;
        add_exp(6, 4, 0);
        push_word(4'd6);
        wait_pops(base + 1, 50);
        repeat (5) begin
            @(posedge clk_i);
            #1;
            check("stall_rd_en", rd_en_o, 0);
            check("stall_valid", res_valid_o, 0);
        end
        check("stall_pops", pops_total, base + 1);
        push_word(4'd4);
        wait_drain(200, 0);

        // Backpressure in DONE with the next operands already queued.
        res_ready_i = 1'b0;
        push_op(12, 8, 1);
        push_op(3, 5, 1);
        for (int i = 0; i < 60 && !res_valid_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("bp_wait_valid", res_valid_o, 1);
        repeat (10) begin
            @(posedge clk_i);
            #1;
            check("bp_valid", res_valid_o, 1);
            check("bp_res", res_o, ref_gcd(12, 8));
            check("bp_rd_en", rd_en_o, 0);
        end
        res_ready_i = 1'b1;
        wait_drain(200, 0);

        // Asynchronous reset in the middle of CALC.
        base = pops_total;
        push_op(15, 1, 1);
        wait_pops(base + 2, 50);
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        void'(exp_q.pop_back());
        void'(calc_q.pop_back());
        void'(first_q.pop_back());
        #1;
        check("async_rst_valid", res_valid_o, 0);
        check("async_rst_res", res_o, 0);
        check("async_rst_rd_en", rd_en_o, 0);
        #1;
        rst_ni = 1'b1;
        push_op(14, 6, 1);
        wait_drain(200, 0);
        check("no_repop", pops_total, base + 4);

        for (int i = 0; i < 16; i++) begin
            push_op($urandom_range(0, 15), $urandom_range(0, 15), 0);
        end
        wait_drain(3000, 1);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
